genome_crossover_ctrl: RTL and testbench

Sequencer for NEAT offspring generation. It merge-walks two key-sorted parent genomes held in synchronous RAMs and applies the crossover and per-attribute mutation decisions to each gene. It streams the resulting child genes to the child genome buffer over a valid/ready port. It sits between the parent genome memories, the shared random source and the child write path in the evolution datapath.

---
 rtl/genome_crossover_ctrl.sv | 138 +++++++++++++
 tb/tb_genome_crossover_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genome_crossover_ctrl.sv
// NEAT offspring sequencer: merge-walks two key-sorted parent genomes, applies
// crossover and per-attribute mutation, and streams child genes out.
module genome_crossover_ctrl #(
  parameter int ADDR_W = 8,
  parameter int GENE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] p1_len,
  input  logic [ADDR_W-1:0] p2_len,
  input  logic [7:0]        mut_prob,
  input  logic [55:0]       rand_i,
  output logic              p1_rd_en,
  output logic              p2_rd_en,
  output logic [ADDR_W-1:0] p1_addr,
  output logic [ADDR_W-1:0] p2_addr,
  input  logic [GENE_W-1:0] p1_data,
  input  logic [GENE_W-1:0] p2_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [GENE_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] child_len
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, CMP, OUT, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] i, j;
  logic [GENE_W-1:0] g1, g2;
  logic [GENE_W-1:0] src, mutated;
  logic [15:0]       k1, k2;
  logic              p2_live, key_match, drop_p2, take_p2;

  // j only advances while parent2 is live, so driving it directly makes the
  // address hold once parent2 is exhausted.
  assign p1_addr   = i;
  assign p2_addr   = j;
  assign p2_live   = (j < p2_len);
  assign k1        = g1[63:48];
  assign k2        = g2[63:48];
  assign key_match = p2_live && (k1 == k2);
  assign drop_p2   = p2_live && (k2 < k1);
  assign take_p2   = key_match && (rand_i[7:0] > 8'h40);
  assign src       = take_p2 ? g2 : g1;

  function automatic logic [7:0] repl_value(input logic is_conn, input int idx,
                                            input logic [7:0] value);
    logic [7:0] r;
    r = 8'h00;
    if (is_conn) begin
      if (idx == 0) r = value & 8'h01;
    end else begin
      case (idx)
        0:       r = value;
        1:       r = value & 8'h0F;
        default: r = value & 8'h07;
      endcase
    end
    return r;
  endfunction

  // attr1 sits in [23:16], so attribute idx occupies bits [23-8*idx -: 8].
  always_comb begin
    mutated = src;
    for (int idx = 0; idx < 3; idx++) begin
      if (rand_i[8+8*idx +: 8] <= mut_prob)
        mutated[23-8*idx -: 8] = repl_value(src[47], idx, rand_i[32+8*idx +: 8]);
    end
  end

  always_comb begin
    state_next = state;
    p1_rd_en   = 1'b0;
    p2_rd_en   = 1'b0;
    wr_valid   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) state_next = (p1_len == '0) ? DONE : RD;
      RD: begin
        p1_rd_en   = 1'b1;
        p2_rd_en   = p2_live;
        state_next = WAIT;
      end
      WAIT: state_next = CMP;
      CMP:  state_next = drop_p2 ? RD : OUT;
      OUT: begin
        wr_valid = 1'b1;
        if (wr_ready) state_next = (i == p1_len) ? DONE : RD;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      g1        <= '0;
      g2        <= '0;
      wr_data   <= '0;
      child_len <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          i         <= '0;
          j         <= '0;
          child_len <= '0;
        end
        WAIT: begin
          g1 <= p1_data;
          if (p2_live) g2 <= p2_data;
        end
        CMP: begin
          if (drop_p2) begin
            j <= j + ADDR_W'(1);
          end else begin
            i       <= i + ADDR_W'(1);
            wr_data <= mutated;
            if (key_match) j <= j + ADDR_W'(1);
          end
        end
        OUT: if (wr_ready) child_len <= child_len + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_genome_crossover_ctrl.sv
// Directed bench for genome_crossover_ctrl with behavioural synchronous parent RAMs.
module tb_genome_crossover_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, wr_ready;
  logic [7:0]  p1_len, p2_len, mut_prob;
  logic [55:0] rand_i;
  logic        p1_rd_en, p2_rd_en, wr_valid, busy, done;
  logic [7:0]  p1_addr, p2_addr, child_len;
  logic [63:0] p1_data, p2_data, wr_data;

  logic [63:0] p1_mem [256];
  logic [63:0] p2_mem [256];

  int total = 0;
  int bad = 0;

  logic [63:0] got [$];
  int          n_done, busy_cycles;
  bit          p2_seen, timed_out;
  logic        busy_after;
  logic [7:0]  len_at_done;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (p1_rd_en) p1_data <= p1_mem[p1_addr];
    if (p2_rd_en) p2_data <= p2_mem[p2_addr];
  end

  genome_crossover_ctrl #(.ADDR_W(8), .GENE_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p1_len(p1_len), .p2_len(p2_len),
    .mut_prob(mut_prob), .rand_i(rand_i), .p1_rd_en(p1_rd_en), .p2_rd_en(p2_rd_en),
    .p1_addr(p1_addr), .p2_addr(p2_addr), .p1_data(p1_data), .p2_data(p2_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .busy(busy),
    .done(done), .child_len(child_len)
  );

  function automatic logic [63:0] mk(input logic [15:0] k, input logic t, input logic [22:0] p,
                                     input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
    return {k, t, p, a1, a2, a3};
  endfunction

  // Pulses start, then observes one negedge per cycle until done (bounded).
  task automatic run(input int pulse_at);
    got.delete();
    busy_cycles = 0;
    p2_seen     = 0;
    timed_out   = 1;
    n_done      = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (p2_rd_en) p2_seen = 1;
      if (wr_valid && wr_ready) begin
        got.push_back(wr_data);
        $display("  gene %0d written: %h", got.size() - 1, wr_data);
      end
      if (done) begin
        n_done      = c;
        len_at_done = child_len;
        timed_out   = 0;
        break;
      end
      if (busy) busy_cycles++;
      start = (c == pulse_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
    p1_len = 0; p2_len = 0; mut_prob = 0; rand_i = '0;
    #12;
    total++;
    if ({busy, done, wr_valid, p1_rd_en, p2_rd_en} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, wr_valid, p1_rd_en, p2_rd_en});
    end
    total++;
    if ({p1_addr, p2_addr, child_len} !== 24'h0 || wr_data !== 64'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", p1_addr, p2_addr, child_len, wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_match(input logic [7:0] sel, input logic [63:0] expected);
    p1_mem[0] = mk(16'd5, 1'b0, 23'h11111, 8'h10, 8'h20, 8'h30);
    p2_mem[0] = mk(16'd5, 1'b0, 23'h22222, 8'hAA, 8'hBB, 8'hCC);
    p1_len = 1; p2_len = 1; mut_prob = 8'h00;
    rand_i = {24'h000000, 24'hFFFFFF, sel};
    run(-1);
    $display("match sel=%h genes=%0d", sel, got.size());
    total++;
    if (timed_out !== 1'b0 || got.size() != 1) begin
      bad++; $display("FAIL match_count sel=%h got=%0d exp=1 timeout=%0d", sel, got.size(), timed_out);
    end else begin
      total++;
      if (got[0] !== expected) begin
        bad++; $display("FAIL match_gene sel=%h got=%h exp=%h", sel, got[0], expected);
      end
    end
    total++;
    if (len_at_done !== 8'd1) begin
      bad++; $display("FAIL match_len got=%0d exp=1", len_at_done);
    end
  endtask

  task automatic test_disjoint();
    logic [63:0] exp_g [3];
    exp_g[0] = mk(16'd1, 1'b0, 23'h00001, 8'h01, 8'h02, 8'h03);
    exp_g[1] = mk(16'd3, 1'b1, 23'h00003, 8'h04, 8'h05, 8'h06);
    exp_g[2] = mk(16'd7, 1'b0, 23'h00007, 8'h07, 8'h08, 8'h09);
    p1_mem[0] = exp_g[0]; p1_mem[1] = exp_g[1]; p1_mem[2] = exp_g[2];
    p2_mem[0] = mk(16'd2, 1'b0, 23'h7FFFF, 8'hE0, 8'hE1, 8'hE2);
    p2_mem[1] = mk(16'd3, 1'b1, 23'h7FFFE, 8'hE3, 8'hE4, 8'hE5);
    p2_mem[2] = mk(16'd4, 1'b0, 23'h7FFFD, 8'hE6, 8'hE7, 8'hE8);
    p2_mem[3] = mk(16'd9, 1'b0, 23'h7FFFC, 8'hE9, 8'hEA, 8'hEB);
    p1_len = 3; p2_len = 4; mut_prob = 8'h00;
    rand_i = {24'h000000, 24'hFFFFFF, 8'h00};
    run(-1);
    $display("disjoint genes=%0d cycles=%0d", got.size(), busy_cycles);
    total++;
    if (timed_out !== 1'b0 || got.size() != 3) begin
      bad++; $display("FAIL disjoint_count got=%0d exp=3 timeout=%0d", got.size(), timed_out);
    end else begin
      for (int g = 0; g < 3; g++) begin
        total++;
        if (got[g] !== exp_g[g]) begin
          bad++; $display("FAIL disjoint_gene%0d got=%h exp=%h", g, got[g], exp_g[g]);
        end
      end
    end
    total++;
    if (len_at_done !== 8'd3) begin
      bad++; $display("FAIL disjoint_len got=%0d exp=3", len_at_done);
    end
    // 3 emits x 4 cycles + 2 drops x 3 cycles
    total++;
    if (busy_cycles != 18) begin
      bad++; $display("FAIL disjoint_cycles got=%0d exp=18", busy_cycles);
    end
    total++;
    if (busy_after !== 1'b0) begin
      bad++; $display("FAIL busy_after_done got=%b exp=0", busy_after);
    end
  endtask

  task automatic test_mutation();
    p1_mem[0] = mk(16'h1234, 1'b0, 23'h5A5A5, 8'h11, 8'h22, 8'h33);
    p1_mem[1] = mk(16'h2345, 1'b1, 23'h2A5A5, 8'h44, 8'h55, 8'h66);
    p1_len = 2; p2_len = 0; mut_prob = 8'h00;
    rand_i = {24'hFFFFFF, 24'h000000, 8'h00};
    run(-1);
    $display("mutation genes=%0d", got.size());
    total++;
    if (timed_out !== 1'b0 || got.size() != 2) begin
      bad++; $display("FAIL mut_count got=%0d exp=2 timeout=%0d", got.size(), timed_out);
    end else begin
      total++;
      if (got[0] !== mk(16'h1234, 1'b0, 23'h5A5A5, 8'hFF, 8'h0F, 8'h07)) begin
        bad++; $display("FAIL mut_node got=%h exp=%h", got[0], mk(16'h1234, 1'b0, 23'h5A5A5, 8'hFF, 8'h0F, 8'h07));
      end
      total++;
      if (got[1] !== mk(16'h2345, 1'b1, 23'h2A5A5, 8'h01, 8'h00, 8'h00)) begin
        bad++; $display("FAIL mut_conn got=%h exp=%h", got[1], mk(16'h2345, 1'b1, 23'h2A5A5, 8'h01, 8'h00, 8'h00));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    bit seen;
    p1_mem[0] = mk(16'h00AB, 1'b1, 23'h70F0F, 8'h5A, 8'hA5, 8'h3C);
    p1_len = 1; p2_len = 0; mut_prob = 8'h00;
    rand_i = {24'h000000, 24'hFFFFFF, 8'h00};
    wr_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (wr_valid) seen = 1; else @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL bp_valid_timeout got=0 exp=1");
    end
    held = wr_data;
    total++;
    if (held !== p1_mem[0]) begin
      bad++; $display("FAIL bp_gene got=%h exp=%h", held, p1_mem[0]);
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (wr_valid !== 1'b1 || wr_data !== held || child_len !== 8'd0) begin
        bad++; $display("FAIL bp_hold cycle=%0d got=%b/%h/%0d exp=1/%h/0", c, wr_valid, wr_data, child_len, held);
      end
      @(negedge clk);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    $display("backpressure released: done=%b child_len=%0d", done, child_len);
    total++;
    if (done !== 1'b1 || wr_valid !== 1'b0 || child_len !== 8'd1) begin
      bad++; $display("FAIL bp_handshake got=%b/%b/%0d exp=1/0/1", done, wr_valid, child_len);
    end
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    p1_len = 0; p2_len = 2;
    run(-1);
    $display("p1_len=0 done_at=%0d genes=%0d", n_done, got.size());
    total++;
    if (n_done != 0 || len_at_done !== 8'd0 || got.size() != 0) begin
      bad++; $display("FAIL empty_p1 got=%0d/%0d/%0d exp=0/0/0", n_done, len_at_done, got.size());
    end
    for (int g = 0; g < 3; g++) p1_mem[g] = mk(16'(10 + g), 1'b0, 23'(g), 8'h01, 8'h02, 8'h03);
    p1_len = 3; p2_len = 0; mut_prob = 8'h00;
    rand_i = {24'h000000, 24'hFFFFFF, 8'h00};
    run(-1);
    $display("p2_len=0 genes=%0d p2_rd=%0d", got.size(), p2_seen);
    total++;
    if (got.size() != 3 || p2_seen !== 1'b0 || len_at_done !== 8'd3) begin
      bad++; $display("FAIL empty_p2 got=%0d/%0d/%0d exp=3/0/3", got.size(), p2_seen, len_at_done);
    end
    run(4);
    $display("start-while-busy genes=%0d", got.size());
    total++;
    if (timed_out !== 1'b0 || got.size() != 3 || len_at_done !== 8'd3) begin
      bad++; $display("FAIL start_busy got=%0d/%0d exp=3/3", got.size(), len_at_done);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    p1_mem[0] = mk(16'd1, 1'b0, 23'h1, 8'h01, 8'h01, 8'h01);
    p1_mem[1] = mk(16'd2, 1'b0, 23'h2, 8'h02, 8'h02, 8'h02);
    p1_len = 2; p2_len = 0; wr_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (wr_valid && child_len == 8'd1) seen = 1; else @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL arst_reach_out got=0 exp=1");
    end
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-OUT");
    total++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || child_len !== 8'd0 || done !== 1'b0) begin
      bad++; $display("FAIL arst_outputs got=%b/%b/%0d/%b exp=0/0/0/0", wr_valid, busy, child_len, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(-1);
    total++;
    if (timed_out !== 1'b0 || got.size() != 2 || len_at_done !== 8'd2) begin
      bad++; $display("FAIL arst_rerun got=%0d/%0d exp=2/2", got.size(), len_at_done);
    end
  endtask

  initial begin
    test_reset();
    test_match(8'h41, mk(16'd5, 1'b0, 23'h22222, 8'hAA, 8'hBB, 8'hCC));
    test_match(8'h40, mk(16'd5, 1'b0, 23'h11111, 8'h10, 8'h20, 8'h30));
    test_disjoint();
    test_mutation();
    test_backpressure();
    test_boundaries();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
